// File: rtl/pspin_cfg_pkg.sv
// -----------------------------------------------------------------------------
// pspin_cfg_pkg
//   Shared configuration and command/response types for HPU-issued commands.
//   Contents:
//     - sizing constants (clusters, cores, per-core command credits)
//     - command interface ids (HostDirect, NIC outbound, EDMA)
//     - pspin_cmd_id_t      : {cluster_id, core_id, local_id}
//     - pspin_cmd_t         : {intf_id, cmd_id, descr}
//     - pspin_cmd_resp_t    : {cmd_id, imm_data}
//     - cmd_credit_t        : per-core in-flight counter (0 .. NUM_HPU_CMDS)
// -----------------------------------------------------------------------------
package pspin_cfg_pkg;

    localparam int NUM_CLUSTERS = 4;
    localparam int NUM_CORES    = 8;
    localparam int NUM_HPU_CMDS = 4;    // power of 2, >= 1

    localparam int CMD_HOSTDIRECT_ID   = 0;
    localparam int CMD_NIC_OUTBOUND_ID = 1;
    localparam int CMD_EDMA_ID         = 2;

    localparam int CLUSTER_ID_W   = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam int CORE_ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CMD_LOCAL_ID_W = (NUM_HPU_CMDS > 1) ? $clog2(NUM_HPU_CMDS) : 1;
    localparam int CMD_INTF_ID_W  = 2;
    localparam int CMD_DESCR_W    = 64;
    localparam int IMM_DATA_W     = 512;

    typedef logic [CMD_INTF_ID_W-1:0] pspin_cmd_intf_id_t;

    typedef struct packed {
        logic [CLUSTER_ID_W-1:0]   cluster_id;
        logic [CORE_ID_W-1:0]      core_id;
        logic [CMD_LOCAL_ID_W-1:0] local_id;
    } pspin_cmd_id_t;

    typedef struct packed {
        pspin_cmd_intf_id_t       intf_id;
        pspin_cmd_id_t            cmd_id;
        logic [CMD_DESCR_W-1:0]   descr;
    } pspin_cmd_t;

    typedef struct packed {
        pspin_cmd_id_t           cmd_id;
        logic [IMM_DATA_W-1:0]   imm_data;
    } pspin_cmd_resp_t;

    typedef logic [$clog2(NUM_HPU_CMDS+1)-1:0] cmd_credit_t;

    localparam cmd_credit_t CREDIT_MAX = cmd_credit_t'(NUM_HPU_CMDS);

endpackage

// File: rtl/cmd_credit_counter.sv
// -----------------------------------------------------------------------------
// cmd_credit_counter
//   In-flight command counter for one core. Counts up on an accepted command,
//   down on its completion; simultaneous inc/dec leaves the count unchanged.
//   A completion seen while the count is 0 is ignored and flagged.
//   Ports:
//     clk_i, rst_ni  clock, async active-low reset
//     inc_i          command accepted for this core
//     dec_i          completion addressed to this core
//     count_o        current in-flight count (0 .. NUM_HPU_CMDS)
//     underflow_o    completion arrived with nothing in flight (combinational)
// -----------------------------------------------------------------------------
module cmd_credit_counter
    import pspin_cfg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        dec_i,
    output cmd_credit_t count_o,
    output logic        underflow_o
);

    cmd_credit_t count_q, count_d;
    logic        dec_ok;

    assign dec_ok      = dec_i && (count_q != '0);
    assign underflow_o = dec_i && (count_q == '0);
    assign count_o     = count_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_ok) begin
            if (count_q != CREDIT_MAX) begin
                count_d = count_q + cmd_credit_t'(1);
            end
        end else if (dec_ok && !inc_i) begin
            count_d = count_q - cmd_credit_t'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cluster_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// cluster_cmd_arbiter
//   Round-robin arbiter and credit tracker for the cluster's HPU commands.
//   One registered output slot is shared by all targets; the granted command
//   is steered by intf_id. Each core may have NUM_HPU_CMDS commands in flight.
//   Completions are registered and returned to the issuing core.
//   Ports:
//     core_valid_i/core_ready_o/core_cmd_i   per-core command handshake
//     intf_valid_o/intf_ready_i/intf_cmd_o   one-hot target handshake, shared cmd
//     resp_valid_i/resp_i                    completion from the cmd unit
//     core_resp_valid_o/core_resp_o          one-hot completion to the core
//     outstanding_o                          per-core in-flight count
//     err_o                                  sticky: bad intf_id or credit underflow
// -----------------------------------------------------------------------------
module cluster_cmd_arbiter
    import pspin_cfg_pkg::*;
#(
    parameter int NUM_CORES          = pspin_cfg_pkg::NUM_CORES,
    parameter int NUM_CMD_INTERFACES = 3,
    parameter int CLUSTER_ID         = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_CORES-1:0]          core_valid_i,
    output logic [NUM_CORES-1:0]          core_ready_o,
    input  pspin_cmd_t                    core_cmd_i [NUM_CORES],
    output logic [NUM_CMD_INTERFACES-1:0] intf_valid_o,
    input  logic [NUM_CMD_INTERFACES-1:0] intf_ready_i,
    output pspin_cmd_t                    intf_cmd_o,
    input  logic                          resp_valid_i,
    input  pspin_cmd_resp_t               resp_i,
    output logic [NUM_CORES-1:0]          core_resp_valid_o,
    output pspin_cmd_resp_t               core_resp_o,
    output cmd_credit_t                   outstanding_o [NUM_CORES],
    output logic                          err_o
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // The slot's one-hot target vector doubles as its valid bit.
    logic [NUM_CMD_INTERFACES-1:0] slot_onehot_q, slot_onehot_d;
    pspin_cmd_t                    slot_cmd_q, slot_cmd_d;
    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic                          err_q, err_d;
    logic [NUM_CORES-1:0]          resp_valid_q;
    pspin_cmd_resp_t               resp_q, resp_d;

    logic                 resp_for_cluster;
    logic [NUM_CORES-1:0] resp_hit, eligible, grant, inc, underflow;
    logic                 slot_drain, slot_free, found, sel_intf_ok;
    logic [PTR_W-1:0]     sel;
    pspin_cmd_t           sel_cmd;

    assign resp_for_cluster = resp_valid_i &&
                              (resp_i.cmd_id.cluster_id == CLUSTER_ID_W'(CLUSTER_ID));

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        assign resp_hit[i] = resp_for_cluster && (resp_i.cmd_id.core_id == CORE_ID_W'(i));
        // A completion in the same cycle frees the credit the new command needs.
        assign eligible[i] = core_valid_i[i] && ((outstanding_o[i] < CREDIT_MAX) || resp_hit[i]);

        cmd_credit_counter u_credit (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (inc[i]),
            .dec_i       (resp_hit[i]),
            .count_o     (outstanding_o[i]),
            .underflow_o (underflow[i])
        );
    end

    assign slot_drain = |(slot_onehot_q & intf_ready_i);
    assign slot_free  = (slot_onehot_q == '0) || slot_drain;

    // Round-robin search starting at ptr_q; the first eligible core wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        if (slot_free && rst_ni) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (!found && eligible[(int'(ptr_q) + k) % NUM_CORES]) begin
                    found = 1'b1;
                    sel   = PTR_W'((int'(ptr_q) + k) % NUM_CORES);
                end
            end
        end
    end

    assign sel_cmd     = core_cmd_i[sel];
    assign sel_intf_ok = int'(sel_cmd.intf_id) < NUM_CMD_INTERFACES;
    assign grant       = found ? (NUM_CORES'(1) << sel) : '0;
    assign inc         = grant & {NUM_CORES{sel_intf_ok}};

    always_comb begin
        slot_onehot_d = slot_drain ? '0 : slot_onehot_q;
        slot_cmd_d    = slot_cmd_q;
        ptr_d         = ptr_q;
        err_d         = err_q | (|underflow);
        resp_d        = resp_for_cluster ? resp_i : resp_q;
        if (found) begin
            ptr_d = (sel == PTR_W'(NUM_CORES - 1)) ? '0 : sel + PTR_W'(1);
            if (sel_intf_ok) begin
                slot_onehot_d = NUM_CMD_INTERFACES'(1) << sel_cmd.intf_id;
                slot_cmd_d    = sel_cmd;
            end else begin
                // Unroutable command: consumed and dropped without a credit.
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_onehot_q <= '0;
            slot_cmd_q    <= '0;
            ptr_q         <= '0;
            err_q         <= 1'b0;
            resp_valid_q  <= '0;
            resp_q        <= '0;
        end else begin
            slot_onehot_q <= slot_onehot_d;
            slot_cmd_q    <= slot_cmd_d;
            ptr_q         <= ptr_d;
            err_q         <= err_d;
            resp_valid_q  <= resp_hit;
            resp_q        <= resp_d;
        end
    end

    assign core_ready_o      = grant;
    assign intf_valid_o      = slot_onehot_q;
    assign intf_cmd_o        = slot_cmd_q;
    assign core_resp_valid_o = resp_valid_q;
    assign core_resp_o       = resp_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_cluster_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cluster_cmd_arbiter
//   Directed scenarios plus randomized traffic, checked every cycle against a
//   transaction-level model (credit array, slot queue, round-robin pointer).
// -----------------------------------------------------------------------------
module tb_cluster_cmd_arbiter;
    import pspin_cfg_pkg::*;

    localparam int NC  = 8;
    localparam int NI  = 3;
    localparam int CID = 0;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NC-1:0]   core_valid_i;
    logic [NC-1:0]   core_ready_o;
    pspin_cmd_t      core_cmd_i [NC];
    logic [NI-1:0]   intf_valid_o;
    logic [NI-1:0]   intf_ready_i;
    pspin_cmd_t      intf_cmd_o;
    logic            resp_valid_i;
    pspin_cmd_resp_t resp_i;
    logic [NC-1:0]   core_resp_valid_o;
    pspin_cmd_resp_t core_resp_o;
    cmd_credit_t     outstanding_o [NC];
    logic            err_o;

    always #5 clk_i = ~clk_i;

    cluster_cmd_arbiter #(
        .NUM_CORES          (NC),
        .NUM_CMD_INTERFACES (NI),
        .CLUSTER_ID         (CID)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .core_valid_i      (core_valid_i),
        .core_ready_o      (core_ready_o),
        .core_cmd_i        (core_cmd_i),
        .intf_valid_o      (intf_valid_o),
        .intf_ready_i      (intf_ready_i),
        .intf_cmd_o        (intf_cmd_o),
        .resp_valid_i      (resp_valid_i),
        .resp_i            (resp_i),
        .core_resp_valid_o (core_resp_valid_o),
        .core_resp_o       (core_resp_o),
        .outstanding_o     (outstanding_o),
        .err_o             (err_o)
    );

    // ---------------- reference model ----------------
    int              m_cnt [NC];
    int              m_ptr;
    pspin_cmd_t      m_slot_q [$];
    bit              m_err;
    logic [NC-1:0]   m_rv;
    pspin_cmd_resp_t m_resp;

    logic [NC-1:0]   exp_ready;
    int              exp_gnt;
    bit              exp_drain;
    bit              exp_resp_hit;
    int              exp_rc;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_ptr = 0;
        m_slot_q.delete();
        m_err  = 1'b0;
        m_rv   = '0;
        m_resp = '0;
    endtask

    task automatic model_eval();
        bit free;
        exp_resp_hit = resp_valid_i && (int'(resp_i.cmd_id.cluster_id) == CID);
        exp_rc       = int'(resp_i.cmd_id.core_id);
        exp_drain    = (m_slot_q.size() != 0) && intf_ready_i[m_slot_q[0].intf_id];
        free         = (m_slot_q.size() == 0) || exp_drain;
        exp_gnt      = -1;
        exp_ready    = '0;
        if (free && rst_ni) begin
            for (int k = 0; k < NC; k++) begin
                int i = (m_ptr + k) % NC;
                if (exp_gnt < 0 && core_valid_i[i] &&
                    (m_cnt[i] < NUM_HPU_CMDS || (exp_resp_hit && exp_rc == i)))
                    exp_gnt = i;
            end
        end
        if (exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
    endtask

    task automatic model_step();
        m_rv = '0;
        if (exp_resp_hit) begin
            if (m_cnt[exp_rc] == 0) m_err = 1'b1;
            else m_cnt[exp_rc]--;
            m_rv[exp_rc] = 1'b1;
            m_resp = resp_i;
        end
        if (exp_drain) void'(m_slot_q.pop_front());
        if (exp_gnt >= 0) begin
            m_ptr = (exp_gnt + 1) % NC;
            if (int'(core_cmd_i[exp_gnt].intf_id) >= NI) m_err = 1'b1;
            else begin
                m_slot_q.push_back(core_cmd_i[exp_gnt]);
                m_cnt[exp_gnt]++;
            end
        end
    endtask

    task automatic compare();
        logic [NI-1:0] ev;
        ev = '0;
        if (m_slot_q.size() != 0) ev[m_slot_q[0].intf_id] = 1'b1;
        check("core_ready", core_ready_o, exp_ready);
        check("intf_valid", intf_valid_o, ev);
        if (m_slot_q.size() != 0) check("intf_cmd", intf_cmd_o, m_slot_q[0]);
        for (int i = 0; i < NC; i++)
            check($sformatf("outstanding[%0d]", i), outstanding_o[i], m_cnt[i]);
        check("err", err_o, m_err);
        check("core_resp_valid", core_resp_valid_o, m_rv);
        if (m_rv != '0) check("core_resp", core_resp_o, m_resp);
    endtask

    // Inputs are driven right after a falling edge; eval samples 1 time unit later.
    task automatic eval();
        #1;
        model_eval();
        compare();
    endtask

    task automatic tick();
        model_step();
        @(negedge clk_i);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic pspin_cmd_t mk_cmd(input int core, input int intf);
        pspin_cmd_t c;
        c.intf_id           = pspin_cmd_intf_id_t'(intf);
        c.cmd_id.cluster_id = CLUSTER_ID_W'(CID);
        c.cmd_id.core_id    = CORE_ID_W'(core);
        c.cmd_id.local_id   = CMD_LOCAL_ID_W'($urandom);
        c.descr             = {$urandom, $urandom};
        return c;
    endfunction

    function automatic pspin_cmd_resp_t mk_resp(input int cluster, input int core);
        pspin_cmd_resp_t r;
        r.cmd_id.cluster_id = CLUSTER_ID_W'(cluster);
        r.cmd_id.core_id    = CORE_ID_W'(core);
        r.cmd_id.local_id   = CMD_LOCAL_ID_W'($urandom);
        for (int k = 0; k < IMM_DATA_W / 32; k++) r.imm_data[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic set_all_cmds(input int intf);
        for (int i = 0; i < NC; i++) core_cmd_i[i] = mk_cmd(i, intf);
    endtask

    task automatic idle();
        core_valid_i = '0;
        intf_ready_i = '1;
        resp_valid_i = 1'b0;
        resp_i       = '0;
        set_all_cmds(0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        check("rst_core_ready", core_ready_o, '0);
        check("rst_intf_valid", intf_valid_o, '0);
        check("rst_core_resp_valid", core_resp_valid_o, '0);
        check("rst_err", err_o, 1'b0);
        for (int i = 0; i < NC; i++) check($sformatf("rst_outstanding[%0d]", i), outstanding_o[i], 0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    pspin_cmd_t held_cmd;
    int         cnt7_before;

    initial begin
        rst_ni = 1'b1;
        idle();
        model_reset();
        @(negedge clk_i);
        do_reset();

        // 1: cores 0,3,5 granted back to back, target NIC outbound
        set_all_cmds(CMD_NIC_OUTBOUND_ID);
        core_valid_i = 8'h29; eval(); check("t1_grant0", core_ready_o, 8'h01); tick();
        core_valid_i = 8'h28; eval(); check("t1_grant3", core_ready_o, 8'h08);
        check("t1_intf_valid_c1", intf_valid_o, 3'b010); tick();
        core_valid_i = 8'h20; eval(); check("t1_grant5", core_ready_o, 8'h20); tick();
        core_valid_i = 8'h00; eval(); check("t1_intf_valid_c3", intf_valid_o, 3'b010);
        check("t1_out0", outstanding_o[0], 1);
        check("t1_out3", outstanding_o[3], 1);
        check("t1_out5", outstanding_o[5], 1); tick();

        // 2: core 2 fills its credits; core 6 still served; same-cycle free/consume
        core_valid_i = 8'h04;
        for (int n = 0; n < 12 && m_cnt[2] < NUM_HPU_CMDS; n++) begin
            core_cmd_i[2] = mk_cmd(2, CMD_NIC_OUTBOUND_ID);
            eval(); tick();
        end
        core_valid_i = 8'h44; eval();
        check("t2_full_count", outstanding_o[2], 4);
        check("t2_core2_blocked", core_ready_o[2], 1'b0);
        check("t2_core6_granted", core_ready_o[6], 1'b1); tick();
        core_valid_i = 8'h04; resp_valid_i = 1'b1; resp_i = mk_resp(CID, 2); eval();
        check("t2_fifth_accepted", core_ready_o, 8'h04); tick();
        core_valid_i = 8'h00; resp_valid_i = 1'b0; eval();
        check("t2_count_back", outstanding_o[2], 4);
        check("t2_resp_pulse", core_resp_valid_o, 8'h04); tick();

        // 3: EDMA target stalls for 5 cycles
        intf_ready_i = 3'b011;
        core_cmd_i[1] = mk_cmd(1, CMD_EDMA_ID); core_valid_i = 8'h02; eval();
        check("t3_accept", core_ready_o, 8'h02); held_cmd = core_cmd_i[1]; tick();
        core_cmd_i[4] = mk_cmd(4, CMD_HOSTDIRECT_ID); core_valid_i = 8'h10;
        for (int n = 0; n < 5; n++) begin
            eval();
            check("t3_no_grant", core_ready_o, 8'h00);
            check("t3_valid_held", intf_valid_o, 3'b100);
            check("t3_cmd_held", intf_cmd_o, held_cmd);
            tick();
        end
        intf_ready_i = 3'b111; eval();
        check("t3_drain_and_grant", core_ready_o, 8'h10); tick();
        core_valid_i = 8'h00; eval();
        check("t3_next_cmd", intf_valid_o, 3'b001); tick();

        // 4: unroutable intf_id
        check("t4_err_before", err_o, 1'b0);
        cnt7_before = m_cnt[7];
        core_cmd_i[7] = mk_cmd(7, 3); core_valid_i = 8'h80; eval();
        check("t4_accept", core_ready_o, 8'h80); tick();
        core_valid_i = 8'h00; eval();
        check("t4_no_intf_valid", intf_valid_o, 3'b000);
        check("t4_err", err_o, 1'b1);
        check("t4_out7", outstanding_o[7], cnt7_before); tick();

        // 5: completion routing, own cluster vs foreign cluster
        resp_valid_i = 1'b1; resp_i = mk_resp(CID, 7); resp_i.imm_data = 512'hA5; eval(); tick();
        resp_valid_i = 1'b0; eval();
        check("t5_pulse", core_resp_valid_o, 8'h80);
        check("t5_imm", core_resp_o.imm_data, 512'hA5); tick();
        resp_valid_i = 1'b1; resp_i = mk_resp(CID + 1, 7); eval(); tick();
        resp_valid_i = 1'b0; eval();
        check("t5_foreign_no_pulse", core_resp_valid_o, 8'h00); tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NC; i++)
                core_cmd_i[i] = mk_cmd(i, ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, NI - 1));
            for (int i = 0; i < NC; i++) core_valid_i[i] = ($urandom_range(0, 9) < 4);
            for (int t = 0; t < NI; t++) intf_ready_i[t] = ($urandom_range(0, 3) != 0);
            resp_valid_i = ($urandom_range(0, 99) < 35);
            begin
                int rc;
                int busy [$];
                rc = $urandom_range(0, NC - 1);
                for (int i = 0; i < NC; i++) if (m_cnt[i] > 0) busy.push_back(i);
                if (busy.size() != 0 && $urandom_range(0, 7) != 0)
                    rc = busy[$urandom_range(0, busy.size() - 1)];
                resp_i = mk_resp(($urandom_range(0, 7) == 0) ? $urandom_range(1, NUM_CLUSTERS - 1) : CID, rc);
            end
            eval(); tick();
        end

        // 6: reset with two commands in flight and the slot full
        idle(); eval(); tick();
        do_reset();
        set_all_cmds(CMD_HOSTDIRECT_ID);
        core_valid_i = 8'h03; eval(); check("t6_grant0", core_ready_o, 8'h01); tick();
        eval(); check("t6_grant1", core_ready_o, 8'h02); tick();
        core_valid_i = 8'hFF; intf_ready_i = 3'b000; eval();
        check("t6_slot_full", intf_valid_o, 3'b001);
        check("t6_out0", outstanding_o[0], 1);
        check("t6_out1", outstanding_o[1], 1);
        do_reset();
        intf_ready_i = 3'b111; eval();
        check("t6_rr_restart", core_ready_o, 8'h01); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
